uart_rx_top: RTL and testbench
==============================

Name: uart_rx_top

Overview:
- UART receiver, the far end of the team's UART TX: 1 start bit, DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit.
- Oversamples RX_IN at PRESCALE clocks per bit and majority-votes 3 mid-bit samples per bit.
- Delivers the parallel word with a 1-cycle DATA_VALID pulse, plus parity and stop error flags.
- Sits in the UART RX clock domain, feeding the system controller.

Parameters:
DATA_WIDTH, 8, data bits per frame
PRESCALE_WIDTH, 6, width of PRESCALE input

Ports:
CLK  input  1  receiver clock (oversampling clock)
RST  input  1  asynchronous, active-high reset
RX_IN  input  1  serial line, idle high, asynchronous to CLK
PRESCALE  input  PRESCALE_WIDTH  clocks per bit; legal values 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last good received word
DATA_VALID  output  1  1-cycle pulse: P_DATA updated with a good frame
PAR_ERR  output  1  1-cycle pulse: parity mismatch
STP_ERR  output  1  1-cycle pulse: stop bit sampled low
BUSY  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: async on RST high. P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0, FSM=IDLE, counters=0, sync flops=1. A reset mid-frame abandons the frame with no output pulse.
- RX_IN passes through a 2-flop synchronizer (rx_s). All FSM decisions use rx_s.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within a bit and wraps to 0 at bit end.
  - bit_cnt counts 0..DATA_WIDTH-1 in DATA.
- Sampling: rx_s is captured while edge_cnt = P/2-1 and P/2. The bit value is the majority of those two captures and rx_s while edge_cnt = P/2+1 (the decision cycle).
- PRESCALE, PAR_EN and PAR_TYP are captured on the IDLE->START transition and held for the frame. Changes mid-frame have no effect.
- FSM:
  - IDLE: rx_s=0 -> START with edge_cnt=0.
  - START: decision=1 (glitch) -> IDLE at the decision edge, no pulses. At edge_cnt=P-1 -> DATA.
  - DATA: at each decision, shift the bit into the data shift register, LSB first. At edge_cnt=P-1: bit_cnt=DATA_WIDTH-1 -> PARITY if PAR_EN else STOP; otherwise bit_cnt+1.
  - PARITY: the decision stores the received parity bit. At edge_cnt=P-1 -> STOP.
  - STOP: at the decision edge, register the outputs and go to IDLE. The remaining half stop bit is not waited out, so a back-to-back start bit is detected correctly.
- Stop-decision outputs, registered, high for exactly 1 cycle:
  - Expected parity = XOR(data) for even, ~XOR(data) for odd.
  - PAR_ERR = PAR_EN & (rx parity != expected).
  - STP_ERR = (stop decision == 0).
  - DATA_VALID = !PAR_ERR & !STP_ERR. P_DATA loads the shift register only when DATA_VALID is set; otherwise P_DATA holds its previous value.
  - PAR_ERR and STP_ERR may assert together.
- Latency: edge 0 is the first CLK edge that samples RX_IN low. Outputs are high in the cycle after edge 9P+P/2+4 without parity, or 10P+P/2+4 with parity. P=8: edge 80 / 88.
- Line held low through STOP: STP_ERR pulses, then IDLE immediately sees rx_s=0 and starts a new frame. This is accepted behaviour (break is not detected specially).
- PRESCALE outside {8,16,32} is unsupported and behaviour is undefined. The verifier does not test it.

Test Plan:
- P=8, PAR_EN=0, frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1 -> DATA_VALID 1 cycle after edge 80, P_DATA=0xA5, PAR_ERR=STP_ERR=0, BUSY falls same cycle.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C, parity bit 0 -> DATA_VALID, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0x3C.
- P=32, PAR_EN=1, PAR_TYP=1, 0x01 with correct odd parity 0, stop bit driven 0 -> STP_ERR pulse only, P_DATA unchanged.
- RX_IN low for 3 clocks in IDLE, then high (P=8) -> FSM returns to IDLE, no output pulses. Also a single-clock high glitch at edge_cnt=P/2 inside a data bit: majority vote keeps the bit value.
- Two back-to-back frames 0x55, 0xAA (P=16), second start bit immediately after a nominal stop bit -> two DATA_VALID pulses, P_DATA=0x55 then 0xAA.
- Assert RST for 1 cycle mid-DATA, then send a fresh 0x7E -> all outputs 0 immediately on reset, no pulse from the aborted frame, 0x7E then received correctly.

Source files
------------

// File: rtl/uart_rx_top_if.sv
// uart_rx_top_if: serial line, frame config and received-word signals of the UART receiver.
// master drives the line and config; slave is the receiver.
interface uart_rx_top_if #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
);
    logic                      RX_IN;
    logic [PRESCALE_WIDTH-1:0] PRESCALE;
    logic                      PAR_EN;
    logic                      PAR_TYP;
    logic [DATA_WIDTH-1:0]     P_DATA;
    logic                      DATA_VALID;
    logic                      PAR_ERR;
    logic                      STP_ERR;
    logic                      BUSY;
    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
    );
endinterface

// File: rtl/uart_rx_top.sv
// uart_rx_top: oversampling UART receiver with 3-sample majority vote, optional parity,
// and one-cycle DATA_VALID / PAR_ERR / STP_ERR pulses at the stop-bit decision.
module uart_rx_top #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input logic          CLK,
    input logic          RST,
    uart_rx_top_if.slave bus
);
    localparam int PW = PRESCALE_WIDTH;
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_n;
    logic                  sync1, rx_s;
    logic [PW-1:0]         pre, edge_cnt, edge_n, half;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic                  par_en_q, par_typ_q;
    logic                  s0, s1, par_bit, decision;
    logic                  bit_end, is_dec, stop_dec, perr, serr;
    logic [DATA_WIDTH-1:0] shreg, p_data;
    logic                  valid, par_err, stp_err;

    assign half     = pre >> 1;
    assign bit_end  = edge_cnt == pre - PW'(1);
    assign is_dec   = edge_cnt == half + PW'(1);
    assign decision = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
    assign stop_dec = state == STOP && is_dec;
    assign perr     = par_en_q & (par_bit != ((^shreg) ^ par_typ_q));
    assign serr     = ~decision;

    always_comb begin
        state_n = state;
        bit_n   = bit_cnt;
        case (state)
            IDLE:    state_n = rx_s ? IDLE : START;
            START:   state_n = (is_dec && decision) ? IDLE : (bit_end ? DATA : START);
            DATA: begin
                bit_n   = bit_end ? ((bit_cnt == LAST) ? '0 : bit_cnt + BW'(1)) : bit_cnt;
                state_n = (bit_end && bit_cnt == LAST) ? (par_en_q ? PARITY : STOP) : DATA;
            end
            PARITY:  state_n = bit_end ? STOP : PARITY;
            STOP:    state_n = is_dec ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
        edge_n = (state == IDLE || state_n == IDLE || bit_end) ? '0 : edge_cnt + PW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1     <= 1'b1;
            rx_s      <= 1'b1;
            state     <= IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            pre       <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            s0        <= 1'b0;
            s1        <= 1'b0;
            par_bit   <= 1'b0;
            shreg     <= '0;
            p_data    <= '0;
            valid     <= 1'b0;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
        end else begin
            sync1    <= bus.RX_IN;
            rx_s     <= sync1;
            state    <= state_n;
            edge_cnt <= edge_n;
            bit_cnt  <= bit_n;
            // frame configuration is frozen for the whole frame at start detection
            if (state == IDLE && !rx_s) begin
                pre       <= bus.PRESCALE;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
            end
            if (edge_cnt == half - PW'(1)) s0 <= rx_s;
            if (edge_cnt == half) s1 <= rx_s;
            if (state == DATA && is_dec) shreg <= {decision, shreg[DATA_WIDTH-1:1]};
            if (state == PARITY && is_dec) par_bit <= decision;
            valid   <= stop_dec & ~perr & ~serr;
            par_err <= stop_dec & perr;
            stp_err <= stop_dec & serr;
            if (stop_dec && !perr && !serr) p_data <= shreg;
        end
    end

    assign bus.P_DATA     = p_data;
    assign bus.DATA_VALID = valid;
    assign bus.PAR_ERR    = par_err;
    assign bus.STP_ERR    = stp_err;
    assign bus.BUSY       = state != IDLE;
endmodule

// File: tb/tb_uart_rx_top.sv
// tb_uart_rx_top: frame-level driver with a queue of expected receiver events, checked by
// an independent monitor whenever the receiver pulses an output.
module tb_uart_rx_top;
    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct {
        logic          v;
        logic          pe;
        logic          se;
        logic [DW-1:0] d;
        int            at;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    logic [DW-1:0] model_pd = '0;
    exp_t          q[$];
    exp_t          e;
    int            ps[3] = '{8, 16, 32};

    uart_rx_top_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();
    uart_rx_top #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 0);
            end else begin
                e = q.pop_front();
                check("data_valid", bus.DATA_VALID, e.v);
                check("par_err", bus.PAR_ERR, e.pe);
                check("stp_err", bus.STP_ERR, e.se);
                check("p_data", bus.P_DATA, e.d);
                check("latency", cyc, e.at);
                check("busy_at_pulse", bus.BUSY, 0);
            end
        end
    end

    // Called at a falling edge; leaves the line idle high at a falling edge.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [DW-1:0] d,
                              input bit bad_par, input bit bad_stop, input bit scramble, input int gbit);
        exp_t x;
        logic pbit;
        pbit = (^d) ^ ptyp ^ bad_par;
        x.pe = pen & bad_par;
        x.se = bad_stop;
        x.v  = !x.pe && !x.se;
        if (x.v) model_pd = d;
        x.d  = model_pd;
        x.at = cyc + 1 + 9 * p + p / 2 + 4 + (pen ? p : 0);
        q.push_back(x);
        bus.PRESCALE = PW'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        bus.RX_IN    = 1'b0;
        repeat (p) @(negedge clk);
        if (scramble) begin
            bus.PRESCALE = PW'(ps[$urandom_range(0, 2)]);
            bus.PAR_EN   = 1'($urandom);
            bus.PAR_TYP  = 1'($urandom);
        end
        for (int i = 0; i < DW; i++) begin
            bus.RX_IN = d[i];
            if (i == gbit) begin
                repeat (p / 2 + 1) @(negedge clk);
                bus.RX_IN = ~d[i];
                @(negedge clk);
                bus.RX_IN = d[i];
                repeat (p / 2 - 2) @(negedge clk);
            end else begin
                repeat (p) @(negedge clk);
            end
        end
        bus.PRESCALE = PW'(p);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        if (pen) begin
            bus.RX_IN = pbit;
            repeat (p) @(negedge clk);
        end
        bus.RX_IN = !bad_stop;
        repeat (p) @(negedge clk);
        bus.RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p, gap;
        bit pen, bp, bs;
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = PW'(8);
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_p_data", bus.P_DATA, 0);
        check("rst_valid", bus.DATA_VALID, 0);
        check("rst_par_err", bus.PAR_ERR, 0);
        check("rst_stp_err", bus.STP_ERR, 0);
        check("rst_busy", bus.BUSY, 0);
        rst = 1'b0;
        idle(5);
        check("idle_busy", bus.BUSY, 0);

        send_frame(8, 0, 0, 8'hA5, 0, 0, 0, -1);
        idle(24);
        send_frame(16, 1, 0, 8'h3C, 0, 0, 0, -1);
        idle(48);
        send_frame(16, 1, 0, 8'h3C, 1, 0, 0, -1);
        idle(48);
        send_frame(32, 1, 1, 8'h01, 0, 1, 0, -1);
        idle(96);

        bus.PRESCALE = PW'(8);
        bus.RX_IN = 1'b0;
        repeat (3) @(negedge clk);
        check("start_glitch_busy", bus.BUSY, 1);
        idle(30);
        check("start_glitch_idle", bus.BUSY, 0);
        send_frame(8, 0, 0, 8'h00, 0, 0, 0, 3);
        idle(24);

        send_frame(16, 0, 0, 8'h55, 0, 0, 0, -1);
        send_frame(16, 0, 0, 8'hAA, 0, 0, 0, -1);
        idle(48);

        bus.PRESCALE = PW'(16);
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            bus.RX_IN = 1'(i);
            repeat (16) @(negedge clk);
        end
        rst = 1'b1;
        bus.RX_IN = 1'b1;
        #1;
        check("midrst_p_data", bus.P_DATA, 0);
        check("midrst_busy", bus.BUSY, 0);
        check("midrst_pulses", {bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 0);
        model_pd = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(20);
        send_frame(16, 0, 0, 8'h7E, 0, 0, 0, -1);
        idle(48);

        for (int n = 0; n < 40; n++) begin
            p   = ps[$urandom_range(0, 2)];
            pen = 1'($urandom);
            bp  = pen && ($urandom_range(0, 3) == 0);
            bs  = $urandom_range(0, 7) == 0;
            send_frame(p, pen, 1'($urandom), 8'($urandom), bp, bs, 1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DW - 1)) : -1);
            gap = bs ? 3 * p : (($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 20)));
            idle(gap);
        end
        idle(100);

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(negedge clk);
        check("queue_drained", q.size(), 0);
        check("final_busy", bus.BUSY, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
